// File: rtl/ntt_pointwise_stream_ctrl.sv
// Stream front end for an N-wide pointwise multiplier array.
// The block collects one frame of A/B coefficient pairs into wide registers
// and waits out the multiplier latency. It then captures the products and
// streams them back out one coefficient per handshake.
module ntt_pointwise_stream_ctrl #(
  parameter int N             = 256,
  parameter int WIDTH         = 32,
  parameter int Q             = 8380417,
  parameter int MULT_PIPELINE = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  input  logic                 in_last,
  output logic [N*WIDTH-1:0]   poly_a_flat,
  output logic [N*WIDTH-1:0]   poly_b_flat,
  input  logic [N*WIDTH-1:0]   poly_c_flat,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_c,
  output logic                 out_last,
  output logic                 busy,
  output logic                 len_err
);

  localparam int WAITC = (MULT_PIPELINE < 1) ? 1 : MULT_PIPELINE;
  localparam int IW    = (N > 1) ? $clog2(N) : 1;
  localparam int CW    = (WAITC > 1) ? $clog2(WAITC) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(WAITC - 1);

  // Q only describes the attached multiplier; this block never does modular math.
  if (Q < 2) begin : g_q_unused
  end

  typedef enum logic [1:0] {S_LOAD, S_WAIT, S_DRAIN} state_t;

  state_t                         state_q, state_d;
  logic [IW-1:0]                  idx_q, idx_d;
  logic [CW-1:0]                  cnt_q, cnt_d;
  logic [N-1:0][WIDTH-1:0]        a_q, a_d, b_q, b_d, c_q, c_d;
  logic                           in_ready_q, in_ready_d;
  logic                           len_err_q, len_err_d;

  // Next-state logic: load slots, count multiplier latency, drain products.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    c_d      = c_q;
    len_err_d = len_err_q;
    case (state_q)
      S_LOAD: begin
        if (in_valid && in_ready_q) begin
          a_d[idx_q] = in_a;
          b_d[idx_q] = in_b;
          if ((idx_q == LAST_IDX) || in_last) begin
            // Short frames are zero-padded so stale slots never reach the multiplier.
            for (int i = 0; i < N; i++) begin
              if (i > int'(idx_q)) begin
                a_d[i] = '0;
                b_d[i] = '0;
              end
            end
            // Error if in_last arrives early or is missing on the final slot.
            if ((idx_q == LAST_IDX) != in_last) len_err_d = 1'b1;
            state_d = S_WAIT;
            idx_d   = '0;
            cnt_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == LAST_CNT) begin
          c_d     = poly_c_flat;
          state_d = S_DRAIN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DRAIN: begin
        if (out_ready) begin
          if (idx_q == LAST_IDX) begin
            state_d = S_LOAD;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = S_LOAD;
    endcase
    in_ready_d = (state_d == S_LOAD);
  end

  // State registers; reset drops any partial frame and clears all buffers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_LOAD;
      idx_q      <= '0;
      cnt_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      c_q        <= '0;
      in_ready_q <= 1'b0;
      len_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      a_q        <= a_d;
      b_q        <= b_d;
      c_q        <= c_d;
      in_ready_q <= in_ready_d;
      len_err_q  <= len_err_d;
    end
  end

  assign poly_a_flat = a_q;
  assign poly_b_flat = b_q;
  assign in_ready    = in_ready_q;
  assign out_valid   = (state_q == S_DRAIN);
  assign out_c       = (state_q == S_DRAIN) ? c_q[idx_q] : '0;
  assign out_last    = (state_q == S_DRAIN) && (idx_q == LAST_IDX);
  assign busy        = (state_q != S_LOAD);
  assign len_err     = len_err_q;

endmodule
